// File: rtl/ucsbece154b_bpu_pkg.sv
// ucsbece154b_bpu_pkg: shared control-flow type encodings and parameter legality helper
package ucsbece154b_bpu_pkg;
  typedef enum logic [1:0] {
    BR_BRANCH = 2'b00,
    BR_JUMP   = 2'b01,
    BR_CALL   = 2'b10,
    BR_RETURN = 2'b11
  } br_type_e;
  function automatic bit ctr_bits_ok(int n);
    return n >= 2 && n <= 3;
  endfunction
endpackage

// File: rtl/ucsbece154b_ras.sv
// ucsbece154b_ras: circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty is ignored.
// Ports: clk, reset (async, active-high), push, pop, push_data -> top, empty, full.
module ucsbece154b_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [CW-1:0] cnt;
  assign ptr_inc = ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
  assign ptr_dec = ptr == '0 ? PW'(DEPTH - 1) : ptr - 1'b1;
  assign top = mem[ptr];
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr_dec;
      cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (!reset && push) mem[ptr_inc] <= push_data;
endmodule

// File: rtl/ucsbece154b_gshare_bpu.sv
// ucsbece154b_gshare_bpu: gshare branch predictor with direct-mapped BTB and optional RAS.
// Ports: clk, reset (async, active-high); fetch side pc_i, fetch_en_i -> pred_taken_o,
// pred_target_o, pred_ghr_o, pred_idx_o; update side upd_valid_i, upd_pc_i, upd_target_i,
// upd_type_i, upd_taken_i, upd_mispredict_i, upd_ghr_i, upd_idx_i.
// Define BPU_RAS_EN to build in the return-address stack.
module ucsbece154b_gshare_bpu
  import ucsbece154b_bpu_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int CTR_BITS        = 2,
  parameter int TAG_BITS        = 8,
  parameter int RAS_DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc_i,
  input  logic                    fetch_en_i,
  output logic                    pred_taken_o,
  output logic [31:0]             pred_target_o,
  output logic [NUM_GHR_BITS-1:0] pred_ghr_o,
  output logic [NUM_GHR_BITS-1:0] pred_idx_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [31:0]             upd_target_i,
  input  logic [1:0]              upd_type_i,
  input  logic                    upd_taken_i,
  input  logic                    upd_mispredict_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic [NUM_GHR_BITS-1:0] upd_idx_i
);
  localparam int IDX = $clog2(NUM_BTB_ENTRIES);
  localparam int NPHT = 1 << NUM_GHR_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  if (!ctr_bits_ok(CTR_BITS) || NUM_BTB_ENTRIES < 4 || RAS_DEPTH < 1) begin : g_bad_params
    $error("ucsbece154b_gshare_bpu: illegal parameter value");
  end
  logic [NUM_BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_BITS-1:0] btb_tag [NUM_BTB_ENTRIES];
  logic [31:0] btb_target [NUM_BTB_ENTRIES];
  br_type_e btb_type [NUM_BTB_ENTRIES];
  logic [CTR_BITS-1:0] pht [NPHT];
  logic [NUM_GHR_BITS-1:0] ghr;
  logic [IDX-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic hit, spec_shift;
  br_type_e f_type;
  logic [31:0] pc_plus4;
  logic [CTR_BITS-1:0] f_ctr, u_ctr, u_ctr_next;
  assign f_idx = pc_i[IDX+1:2];
  assign f_tag = pc_i[TAG_BITS+IDX+1:IDX+2];
  assign u_idx = upd_pc_i[IDX+1:2];
  assign u_tag = upd_pc_i[TAG_BITS+IDX+1:IDX+2];
  assign hit = btb_valid[f_idx] && btb_tag[f_idx] == f_tag;
  assign f_type = btb_type[f_idx];
  assign pc_plus4 = pc_i + 32'd4;
  assign pred_idx_o = pc_i[NUM_GHR_BITS+1:2] ^ ghr;
  assign pred_ghr_o = ghr;
  assign f_ctr = pht[pred_idx_o];
  assign pred_taken_o = hit && (f_type != BR_BRANCH || f_ctr[CTR_BITS-1]);
  assign spec_shift = fetch_en_i && hit && f_type == BR_BRANCH;
  assign u_ctr = pht[upd_idx_i];
  assign u_ctr_next = upd_taken_i ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + 1'b1)
                                  : (u_ctr == '0 ? u_ctr : u_ctr - 1'b1);
`ifdef BPU_RAS_EN
  logic [31:0] ras_top;
  logic ras_empty, ras_full, unused_ras;
  ucsbece154b_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (fetch_en_i && hit && f_type == BR_CALL),
    .pop      (fetch_en_i && hit && f_type == BR_RETURN),
    .push_data(pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );
  assign unused_ras = ras_full;
  assign pred_target_o = !hit ? pc_plus4
                       : (f_type == BR_RETURN && !ras_empty) ? ras_top : btb_target[f_idx];
`else
  assign pred_target_o = hit ? btb_target[f_idx] : pc_plus4;
`endif
  logic unused_bits;
  assign unused_bits = ^{pc_i[31:TAG_BITS+IDX+2], pc_i[1:0],
                         upd_pc_i[31:TAG_BITS+IDX+2], upd_pc_i[1:0]};
  // Mispredict recovery takes priority over the speculative shift of the same cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) ghr <= '0;
    else if (upd_valid_i && upd_mispredict_i)
      ghr <= upd_type_i == BR_BRANCH ? {upd_ghr_i[NUM_GHR_BITS-2:0], upd_taken_i} : upd_ghr_i;
    else if (spec_shift) ghr <= {ghr[NUM_GHR_BITS-2:0], pred_taken_o};
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NPHT; i++) pht[i] <= CTR_INIT;
    else if (upd_valid_i && upd_type_i == BR_BRANCH) pht[upd_idx_i] <= u_ctr_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) btb_valid <= '0;
    else if (upd_valid_i && upd_taken_i) btb_valid[u_idx] <= 1'b1;
  // Payload needs no reset: it is qualified by the valid bits.
  always_ff @(posedge clk)
    if (!reset && upd_valid_i && upd_taken_i) begin
      btb_tag[u_idx] <= u_tag;
      btb_target[u_idx] <= upd_target_i;
      btb_type[u_idx] <= br_type_e'(upd_type_i);
    end
endmodule
